ttws_bus_arbiter: RTL and testbench

TTWS_BUS_ARBITER -- requirements
Module: ttws_bus_arbiter

---
 rtl/ttws_bus_arbiter.sv | 85 ++++++++
 tb/tb_ttws_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ttws_bus_arbiter.sv
// ttws_bus_arbiter: 4-way round-robin bus arbiter with bounded bursts
module ttws_bus_arbiter #(
    parameter int W = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] data_in,
    output logic [3:0]     grant,
    output logic [W-1:0]   bus_out,
    output logic           bus_valid,
    output logic           bus_last,
    output logic           busy
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MB = CW'(MAX_BURST);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, ptr_nx, g, base, sel;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0] grant_nx;
    logic [W-1:0] bus_out_nx;
    logic valid_nx, last_nx, found, beat, rel;
    assign g = {grant[3] | grant[2], grant[3] | grant[1]};
    assign busy = |grant;
    assign cnt_inc = cnt + CW'(1);
    assign beat = state == BUSY && req[g];
    assign rel = state == BUSY && (!req[g] || cnt_inc == MB);
    // on release the just-served index becomes the pointer, so it is searched last
    assign base = state == BUSY ? g : ptr;
    always_comb begin
        found = 1'b0;
        sel = base;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[base + 2'(k)]) begin
                found = 1'b1;
                sel = base + 2'(k);
            end
        end
    end
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        ptr_nx = ptr;
        cnt_nx = cnt;
        bus_out_nx = bus_out;
        valid_nx = 1'b0;
        last_nx = 1'b0;
        if (ena) begin
            if (beat) begin
                bus_out_nx = data_in[int'(g)*W +: W];
                valid_nx = 1'b1;
                cnt_nx = cnt_inc;
                last_nx = cnt_inc == MB;
            end
            if (state == IDLE || rel) begin
                ptr_nx = base;
                grant_nx = found ? 4'b1 << sel : 4'b0;
                cnt_nx = '0;
                state_nx = found ? BUSY : IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr <= 2'd3;
            cnt <= '0;
            bus_out <= '0;
            bus_valid <= 1'b0;
            bus_last <= 1'b0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            ptr <= ptr_nx;
            cnt <= cnt_nx;
            bus_out <= bus_out_nx;
            bus_valid <= valid_nx;
            bus_last <= last_nx;
        end
    end
endmodule

// File: tb/tb_ttws_bus_arbiter.sv
// tb_ttws_bus_arbiter: directed vector table, async reset sequence and a
// randomised run checked against a reference model through a scoreboard queue.
module tb_ttws_bus_arbiter;
    localparam int W = 8;
    localparam int MB = 4;
    localparam logic [4*W-1:0] D = 32'h4433_22A5;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [3:0] req = '0;
    logic [4*W-1:0] data_in = '0;
    logic [3:0] grant;
    logic [W-1:0] bus_out;
    logic bus_valid, bus_last, busy;
    ttws_bus_arbiter #(.W(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .data_in(data_in),
        .grant(grant), .bus_out(bus_out), .bus_valid(bus_valid),
        .bus_last(bus_last), .busy(busy)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   grant;
        logic [W-1:0] out;
        logic         valid;
        logic         last;
    } exp_t;
    typedef struct {
        logic       ena;
        logic [3:0] req;
        exp_t       e;
    } vec_t;
    exp_t sb[$];
    vec_t vecs[$];
    int n_cmp = 0, n_err = 0;
    logic rnd_phase = 1'b0;
    logic [3:0] prev_grant = '0;
    int wait_cnt[4];
    int m_g, m_ptr, m_cnt;
    logic [W-1:0] m_out;
    logic m_valid, m_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] r, input logic [3:0] gr,
                       input logic [W-1:0] o, input logic v, input logic l, input int n);
        vec_t x;
        x.ena = e;
        x.req = r;
        x.e = '{gr, o, v, l};
        for (int i = 0; i < n; i++) vecs.push_back(x);
    endtask

    task automatic drive(input logic e, input logic [3:0] r, input logic [4*W-1:0] d, input exp_t x);
        ena = e;
        req = r;
        data_in = d;
        sb.push_back(x);
    endtask

    function automatic int arb(input int p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1; m_ptr = 3; m_cnt = 0; m_out = '0; m_valid = 1'b0; m_last = 1'b0;
    endtask

    // advances the model by one rising edge using the inputs currently driven
    task automatic model_step();
        logic release_now;
        if (!ena) begin
            m_valid = 1'b0; m_last = 1'b0;
        end else if (m_g < 0) begin
            m_valid = 1'b0; m_last = 1'b0;
            m_g = arb(m_ptr, req);
            m_cnt = 0;
        end else begin
            if (req[m_g]) begin
                m_out = data_in[m_g*W +: W];
                m_valid = 1'b1;
                m_cnt++;
                m_last = m_cnt == MB;
                release_now = m_last;
            end else begin
                m_valid = 1'b0; m_last = 1'b0;
                release_now = 1'b1;
            end
            if (release_now) begin
                m_ptr = m_g;
                m_g = arb(m_ptr, req);
                m_cnt = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int worst;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant", 32'(grant), 32'(e.grant));
            chk("bus_out", 32'(bus_out), 32'(e.out));
            chk("bus_valid", 32'(bus_valid), 32'(e.valid));
            chk("bus_last", 32'(bus_last), 32'(e.last));
            chk("busy", 32'(busy), 32'(|e.grant));
        end
        if (rnd_phase) begin
            chk("onehot", 32'($onehot0(grant)), 32'd1);
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || grant[i]) wait_cnt[i] = 0;
                else if (grant != 4'b0 && grant != prev_grant) wait_cnt[i]++;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            prev_grant = grant;
            chk("starve", 32'(worst > 3), 32'd0);
        end
    end

    initial begin
        add(0, 4'b0001, 4'b0000, 8'h00, 0, 0, 1);
        add(1, 4'b0001, 4'b0001, 8'h00, 0, 0, 1);
        add(1, 4'b0001, 4'b0001, 8'hA5, 1, 0, 3);
        add(1, 4'b0001, 4'b0001, 8'hA5, 1, 1, 1);
        add(1, 4'b0001, 4'b0001, 8'hA5, 1, 0, 1);
        add(1, 4'b1111, 4'b0001, 8'hA5, 1, 0, 2);
        add(1, 4'b1111, 4'b0010, 8'hA5, 1, 1, 1);
        add(1, 4'b1111, 4'b0010, 8'h22, 1, 0, 3);
        add(1, 4'b1111, 4'b0100, 8'h22, 1, 1, 1);
        add(1, 4'b1111, 4'b0100, 8'h33, 1, 0, 3);
        add(1, 4'b1111, 4'b1000, 8'h33, 1, 1, 1);
        add(1, 4'b1111, 4'b1000, 8'h44, 1, 0, 3);
        add(1, 4'b1111, 4'b0001, 8'h44, 1, 1, 1);
        add(1, 4'b1111, 4'b0001, 8'hA5, 1, 0, 2);
        add(1, 4'b0100, 4'b0100, 8'hA5, 0, 0, 1);
        add(1, 4'b0100, 4'b0100, 8'h33, 1, 0, 2);
        add(0, 4'b0100, 4'b0100, 8'h33, 0, 0, 3);
        add(1, 4'b0100, 4'b0100, 8'h33, 1, 0, 1);
        add(1, 4'b0100, 4'b0100, 8'h33, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 8'h33, 0, 0, 2);
        add(1, 4'b1111, 4'b1000, 8'h33, 0, 0, 1);
        add(1, 4'b1111, 4'b1000, 8'h44, 1, 0, 2);

        #12;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_last", 32'(bus_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].ena, vecs[i].req, D, vecs[i].e);
        end

        // asynchronous reset in the middle of a burst
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_bus_out", 32'(bus_out), 32'd0);
        chk("async_valid", 32'(bus_valid), 32'd0);
        chk("async_last", 32'(bus_last), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b1010, D, '{4'b0010, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        drive(1'b1, 4'b1010, D, '{4'b0010, 8'h22, 1'b1, 1'b0});

        @(negedge clk);
        rst_n = 1'b0;
        ena = 1'b0;
        req = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        prev_grant = '0;
        rnd_phase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] r;
            exp_t x;
            @(negedge clk);
            r = req;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            ena = $urandom_range(15) != 0;
            req = r;
            data_in = {$urandom};
            model_step();
            x = '{m_g < 0 ? 4'b0 : 4'(1 << m_g), m_out, m_valid, m_last};
            sb.push_back(x);
        end
        @(negedge clk);
        rnd_phase = 1'b0;
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected results left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
